spring_array: RTL and testbench
===============================

SPRING_ARRAY -- requirements
Module: spring_array

Interface
REQ-001 Parameters SHALL be: NUM_SPRINGS, default 4, number of spring channels per batch.
REQ-002 CONSTANT_SIZE, default 3, signed width of k and b.
REQ-003 POSITION_SIZE, default 8, signed width of coordinates and unsigned width of equilibrium.
REQ-004 VELOCITY_SIZE, default 7, signed width of velocities.
REQ-005 FORCE_SIZE, default 8, signed width of force outputs.
REQ-006 Ports, one clock; reset is asynchronous and active-high:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- input_valid  in  1  batch request.
- input_ready  out  1  block idle, batch accepted.
- k[NUM_SPRINGS], b[NUM_SPRINGS]  in  CONSTANT_SIZE each  stiffness and damping.
- x1, y1, x2, y2 [NUM_SPRINGS]  in  POSITION_SIZE each  endpoint coordinates.
- vel1_x, vel1_y, vel2_x, vel2_y [NUM_SPRINGS]  in  VELOCITY_SIZE each  endpoint velocities.
- equilibrium[NUM_SPRINGS]  in  POSITION_SIZE  rest length.
- force_x, force_y [NUM_SPRINGS]  out  FORCE_SIZE each  force on endpoint 1.
- result_valid  out  1  one-cycle batch-complete pulse.

Function
REQ-007 A batch SHALL be accepted when input_valid and input_ready are both high on a rising clk_in; all channel inputs SHALL be registered at acceptance and later input changes SHALL NOT affect the batch.
REQ-008 input_ready SHALL be high only in IDLE; input_valid outside IDLE SHALL be ignored.
REQ-009 Channels SHALL be processed sequentially, index 0 first, by one shared datapath.
REQ-010 Per channel: dx=x2-x1, dy=y2-y1 at POSITION_SIZE+1 bits; len=floor(sqrt(dx^2+dy^2)); stretch=len-equilibrium (signed).
REQ-011 Spring term: sx=trunc0(k*stretch*dx/len), sy=trunc0(k*stretch*dy/len), rounding toward zero; when len=0, sx=sy=0.
REQ-012 Damping term: dxv=b*(vel2_x-vel1_x), dyv=b*(vel2_y-vel1_y).
REQ-013 force_x=sat(sx+dxv), force_y=sat(sy+dyv), saturated to [-2^(FORCE_SIZE-1), 2^(FORCE_SIZE-1)-1]; intermediates SHALL be wide enough that no wrap occurs before saturation.
REQ-014 FSM states: IDLE, LOAD (1 cycle), SQRT (POSITION_SIZE+1 cycles, restoring, 1 bit/cycle), MUL (1 cycle), DIV (CONSTANT_SIZE+POSITION_SIZE+2 cycles, x and y dividers in parallel), STORE (1 cycle).
REQ-015 Transitions: IDLE->LOAD on accept; LOAD->SQRT->MUL->DIV->STORE; STORE->LOAD if channels remain, else STORE->IDLE.
REQ-016 Cycles per channel SHALL be C=2*POSITION_SIZE+CONSTANT_SIZE+6 (25 at defaults).
REQ-017 result_valid SHALL pulse for exactly one cycle, NUM_SPRINGS*C+1 cycles after the accept edge (101 at defaults), coincident with the first IDLE cycle.
REQ-018 A new batch MAY be accepted in the same cycle result_valid is high.
REQ-019 force_x/force_y for a channel SHALL update only at that channel's STORE. They SHALL hold until overwritten by a later batch.
REQ-020 Channels with len=0 SHALL still take the full C cycles.

Reset
REQ-021 rst_in high SHALL immediately and asynchronously force IDLE, all force outputs to 0, result_valid to 0, and input_ready to 1 after release.
REQ-022 Reset mid-batch SHALL abort the batch with no result_valid pulse; the next accepted batch SHALL complete normally.

Verification
REQ-023 k=1,b=0,eq=2, (2,2)-(2,4), zero velocities -> force (0,0), result_valid exactly 101 cycles after accept.
REQ-024 k=1,b=0,eq=2: (2,2)-(2,5) -> (0,1); (2,2)-(5,6) -> (1,2) in channels 0 and 1 of one batch.
REQ-025 k=3,b=0,eq=0, (-13,-8)-(98,111) -> len 162, unsaturated 333 -> force (127,127).
REQ-026 k=1,b=1, coincident (3,3)-(3,3), vel1=(5,6), vel2=(-5,6) -> force (-10,0); cycle count unchanged.
REQ-027 Assert rst_in at cycle 40 of a batch -> outputs 0, no result_valid; input_valid held high during busy is ignored; back-to-back accept on the result_valid cycle completes.

Source files
------------

// File: rtl/spring_array.sv
// Batched spring-force engine: one shared sqrt/mul/div datapath walks channels 0..NUM_SPRINGS-1.
// Latency NUM_SPRINGS*(2*P+K+6)+1 cycles to result_valid; input_ready low while busy, outputs never stall.
module spring_array #(
    parameter int NUM_SPRINGS   = 4,
    parameter int CONSTANT_SIZE = 3,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 7,
    parameter int FORCE_SIZE    = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic signed [CONSTANT_SIZE-1:0] k            [NUM_SPRINGS],
    input  logic signed [CONSTANT_SIZE-1:0] b            [NUM_SPRINGS],
    input  logic signed [POSITION_SIZE-1:0] x1           [NUM_SPRINGS],
    input  logic signed [POSITION_SIZE-1:0] y1           [NUM_SPRINGS],
    input  logic signed [POSITION_SIZE-1:0] x2           [NUM_SPRINGS],
    input  logic signed [POSITION_SIZE-1:0] y2           [NUM_SPRINGS],
    input  logic signed [VELOCITY_SIZE-1:0] vel1_x       [NUM_SPRINGS],
    input  logic signed [VELOCITY_SIZE-1:0] vel1_y       [NUM_SPRINGS],
    input  logic signed [VELOCITY_SIZE-1:0] vel2_x       [NUM_SPRINGS],
    input  logic signed [VELOCITY_SIZE-1:0] vel2_y       [NUM_SPRINGS],
    input  logic        [POSITION_SIZE-1:0] equilibrium  [NUM_SPRINGS],
    output logic signed [FORCE_SIZE-1:0]    force_x      [NUM_SPRINGS],
    output logic signed [FORCE_SIZE-1:0]    force_y      [NUM_SPRINGS],
    output logic                            result_valid
);
    localparam int P    = POSITION_SIZE;
    localparam int LW   = P + 1;
    localparam int RADW = 2 * LW;
    localparam int REMW = P + 2;
    localparam int STW  = P + 2;
    localparam int QW   = CONSTANT_SIZE + P + 2;
    localparam int NW   = CONSTANT_SIZE + 2 * P + 3;
    localparam int VDW  = VELOCITY_SIZE + 1;
    localparam int DMW  = CONSTANT_SIZE + VDW;
    localparam int TW   = ((NW > DMW) ? NW : DMW) + 2;
    localparam int CNTW = $clog2(QW + 1);
    localparam int CHW  = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
    localparam logic signed [TW-1:0] FMAX = TW'((2 ** (FORCE_SIZE - 1)) - 1);
    localparam logic signed [TW-1:0] FMIN = ~FMAX;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQRT, S_MUL, S_DIV, S_STORE} state_t;

    state_t                      r_state;
    logic                        r_ready;
    logic                        r_vld;
    logic [CHW-1:0]              r_ch;
    logic [CNTW-1:0]             r_cnt;
    logic signed [CONSTANT_SIZE-1:0] r_k   [NUM_SPRINGS];
    logic signed [CONSTANT_SIZE-1:0] r_b   [NUM_SPRINGS];
    logic signed [P-1:0]         r_x1  [NUM_SPRINGS];
    logic signed [P-1:0]         r_y1  [NUM_SPRINGS];
    logic signed [P-1:0]         r_x2  [NUM_SPRINGS];
    logic signed [P-1:0]         r_y2  [NUM_SPRINGS];
    logic signed [VELOCITY_SIZE-1:0] r_v1x [NUM_SPRINGS];
    logic signed [VELOCITY_SIZE-1:0] r_v1y [NUM_SPRINGS];
    logic signed [VELOCITY_SIZE-1:0] r_v2x [NUM_SPRINGS];
    logic signed [VELOCITY_SIZE-1:0] r_v2y [NUM_SPRINGS];
    logic [P-1:0]                r_eq  [NUM_SPRINGS];
    logic signed [FORCE_SIZE-1:0] r_fx [NUM_SPRINGS];
    logic signed [FORCE_SIZE-1:0] r_fy [NUM_SPRINGS];

    logic signed [LW-1:0]        r_dx, r_dy;
    logic [RADW-1:0]             r_rad;
    logic [REMW-1:0]             r_rem;
    logic [LW-1:0]               r_root;
    logic signed [CONSTANT_SIZE-1:0] r_kc, r_bc;
    logic [P-1:0]                r_eqc;
    logic signed [VDW-1:0]       r_dvx, r_dvy;
    logic [NW-1:0]               r_nx, r_ny, r_div;
    logic                        r_negx, r_negy;
    logic [QW-1:0]               r_qx, r_qy;

    logic signed [LW-1:0]        w_dx, w_dy;
    logic [RADW-1:0]             w_rad;
    logic [REMW+1:0]             w_rem_sh, w_trial;
    logic                        w_ge_sq;
    logic signed [STW-1:0]       w_stretch;
    logic signed [NW-1:0]        w_num_x, w_num_y;
    logic                        w_gex, w_gey;
    logic signed [TW-1:0]        w_qxe, w_qye, w_sx, w_sy, w_totx, w_toty;

    function automatic logic signed [FORCE_SIZE-1:0] f_sat(input logic signed [TW-1:0] v);
        if (v > FMAX)      return FORCE_SIZE'(FMAX);
        else if (v < FMIN) return FORCE_SIZE'(FMIN);
        else               return FORCE_SIZE'(v);
    endfunction

    always_comb begin
        w_dx      = LW'(r_x2[r_ch]) - LW'(r_x1[r_ch]);
        w_dy      = LW'(r_y2[r_ch]) - LW'(r_y1[r_ch]);
        w_rad     = RADW'(w_dx) * RADW'(w_dx) + RADW'(w_dy) * RADW'(w_dy);
        // Restoring sqrt step: bring down two radicand bits, try root*4+1.
        w_rem_sh  = {r_rem, r_rad[RADW-1 -: 2]};
        w_trial   = (REMW + 2)'({r_root, 2'b01});
        w_ge_sq   = (w_rem_sh >= w_trial);
        w_stretch = $signed({1'b0, r_root}) - $signed(STW'(r_eqc));
        w_num_x   = NW'(r_kc) * NW'(w_stretch) * NW'(r_dx);
        w_num_y   = NW'(r_kc) * NW'(w_stretch) * NW'(r_dy);
        w_gex     = (r_nx >= r_div);
        w_gey     = (r_ny >= r_div);
        w_qxe     = TW'(r_qx);
        w_qye     = TW'(r_qy);
        // Divide on magnitudes then reapply sign: truncation toward zero.
        w_sx      = (r_root == '0) ? '0 : (r_negx ? -w_qxe : w_qxe);
        w_sy      = (r_root == '0) ? '0 : (r_negy ? -w_qye : w_qye);
        w_totx    = w_sx + TW'(r_bc) * TW'(r_dvx);
        w_toty    = w_sy + TW'(r_bc) * TW'(r_dvy);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_vld   <= 1'b0;
            r_ch    <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_SPRINGS; i++) begin
                r_k[i]   <= '0; r_b[i]   <= '0;
                r_x1[i]  <= '0; r_y1[i]  <= '0; r_x2[i]  <= '0; r_y2[i]  <= '0;
                r_v1x[i] <= '0; r_v1y[i] <= '0; r_v2x[i] <= '0; r_v2y[i] <= '0;
                r_eq[i]  <= '0; r_fx[i]  <= '0; r_fy[i]  <= '0;
            end
            r_dx   <= '0; r_dy   <= '0; r_rad  <= '0; r_rem <= '0; r_root <= '0;
            r_kc   <= '0; r_bc   <= '0; r_eqc  <= '0; r_dvx <= '0; r_dvy  <= '0;
            r_nx   <= '0; r_ny   <= '0; r_div  <= '0; r_negx <= 1'b0; r_negy <= 1'b0;
            r_qx   <= '0; r_qy   <= '0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (input_valid) begin
                        r_k   <= k;      r_b   <= b;
                        r_x1  <= x1;     r_y1  <= y1;     r_x2  <= x2;     r_y2  <= y2;
                        r_v1x <= vel1_x; r_v1y <= vel1_y; r_v2x <= vel2_x; r_v2y <= vel2_y;
                        r_eq  <= equilibrium;
                        r_ready <= 1'b0;
                        r_ch    <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_dx   <= w_dx;
                    r_dy   <= w_dy;
                    r_rad  <= w_rad;
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                    r_kc   <= r_k[r_ch];
                    r_bc   <= r_b[r_ch];
                    r_eqc  <= r_eq[r_ch];
                    r_dvx  <= VDW'(r_v2x[r_ch]) - VDW'(r_v1x[r_ch]);
                    r_dvy  <= VDW'(r_v2y[r_ch]) - VDW'(r_v1y[r_ch]);
                    r_state <= S_SQRT;
                end
                S_SQRT: begin
                    r_rad <= r_rad << 2;
                    if (w_ge_sq) begin
                        r_rem  <= REMW'(w_rem_sh - w_trial);
                        r_root <= {r_root[LW-2:0], 1'b1};
                    end else begin
                        r_rem  <= REMW'(w_rem_sh);
                        r_root <= {r_root[LW-2:0], 1'b0};
                    end
                    if (r_cnt == CNTW'(P)) begin
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_MUL: begin
                    r_negx  <= w_num_x[NW-1];
                    r_negy  <= w_num_y[NW-1];
                    r_nx    <= w_num_x[NW-1] ? $unsigned(-w_num_x) : $unsigned(w_num_x);
                    r_ny    <= w_num_y[NW-1] ? $unsigned(-w_num_y) : $unsigned(w_num_y);
                    // Quotient is bounded by |k*stretch| < 2^QW, so QW shifted-divisor steps suffice.
                    r_div   <= NW'(r_root) << (QW - 1);
                    r_qx    <= '0;
                    r_qy    <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    if (w_gex) r_nx <= r_nx - r_div;
                    if (w_gey) r_ny <= r_ny - r_div;
                    r_qx  <= {r_qx[QW-2:0], w_gex};
                    r_qy  <= {r_qy[QW-2:0], w_gey};
                    r_div <= r_div >> 1;
                    if (r_cnt == CNTW'(QW - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_STORE: begin
                    r_fx[r_ch] <= f_sat(w_totx);
                    r_fy[r_ch] <= f_sat(w_toty);
                    if (r_ch == CHW'(NUM_SPRINGS - 1)) begin
                        r_ch    <= '0;
                        r_ready <= 1'b1;
                        r_vld   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_ch    <= r_ch + CHW'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign input_ready  = r_ready;
    assign result_valid = r_vld;
    assign force_x      = r_fx;
    assign force_y      = r_fy;
endmodule

// File: tb/tb_spring_array.sv
// Bench for spring_array: directed table, back-to-back/busy/reset sequences, and random batches vs a reference model.
module tb_spring_array;
    localparam int NS = 4, KS = 3, PS = 8, VS = 7, FS = 8;
    localparam int LAT = NS * (2 * PS + KS + 6) + 1;

    logic clk_in = 1'b0;
    logic rst_in, input_valid, input_ready, result_valid;
    logic signed [KS-1:0] t_k [NS], t_b [NS];
    logic signed [PS-1:0] t_x1 [NS], t_y1 [NS], t_x2 [NS], t_y2 [NS];
    logic signed [VS-1:0] t_v1x [NS], t_v1y [NS], t_v2x [NS], t_v2y [NS];
    logic [PS-1:0]        t_eq [NS];
    logic signed [FS-1:0] fx [NS], fy [NS];

    always #5 clk_in = ~clk_in;

    spring_array #(.NUM_SPRINGS(NS), .CONSTANT_SIZE(KS), .POSITION_SIZE(PS),
                   .VELOCITY_SIZE(VS), .FORCE_SIZE(FS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .input_valid(input_valid), .input_ready(input_ready),
        .k(t_k), .b(t_b), .x1(t_x1), .y1(t_y1), .x2(t_x2), .y2(t_y2),
        .vel1_x(t_v1x), .vel1_y(t_v1y), .vel2_x(t_v2x), .vel2_y(t_v2y),
        .equilibrium(t_eq), .force_x(fx), .force_y(fy), .result_valid(result_valid)
    );

    typedef struct {int k, b, x1, y1, x2, y2, v1x, v1y, v2x, v2y, eq, fx, fy;} vec_t;
    vec_t tbl [8];
    int checks = 0, errors = 0;
    int e_fx [NS], e_fy [NS], a_fx [NS], a_fy [NS];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 2 ** (FS - 1) - 1) return 2 ** (FS - 1) - 1;
        if (v < -(2 ** (FS - 1)))  return -(2 ** (FS - 1));
        return v;
    endfunction

    // Reference: plain integer arithmetic; SV int division truncates toward zero.
    task automatic model(input vec_t v, output int ofx, output int ofy);
        int dx, dy, s, len, st, sx, sy;
        dx = v.x2 - v.x1;
        dy = v.y2 - v.y1;
        s = dx * dx + dy * dy;
        len = 0;
        while ((len + 1) * (len + 1) <= s) len++;
        st = len - v.eq;
        sx = (len == 0) ? 0 : (v.k * st * dx) / len;
        sy = (len == 0) ? 0 : (v.k * st * dy) / len;
        ofx = sat(sx + v.b * (v.v2x - v.v1x));
        ofy = sat(sy + v.b * (v.v2y - v.v1y));
    endtask

    task automatic set_ch(input int c, input vec_t v);
        t_k[c]   = KS'(v.k);   t_b[c]   = KS'(v.b);
        t_x1[c]  = PS'(v.x1);  t_y1[c]  = PS'(v.y1);  t_x2[c]  = PS'(v.x2);  t_y2[c]  = PS'(v.y2);
        t_v1x[c] = VS'(v.v1x); t_v1y[c] = VS'(v.v1y); t_v2x[c] = VS'(v.v2x); t_v2y[c] = VS'(v.v2y);
        t_eq[c]  = PS'(v.eq);
        e_fx[c]  = v.fx;       e_fy[c]  = v.fy;
    endtask

    task automatic scramble();
        for (int c = 0; c < NS; c++) begin
            t_k[c] = KS'($urandom); t_b[c] = KS'($urandom);
            t_x1[c] = PS'($urandom); t_y1[c] = PS'($urandom);
            t_x2[c] = PS'($urandom); t_y2[c] = PS'($urandom);
            t_v1x[c] = VS'($urandom); t_v1y[c] = VS'($urandom);
            t_v2x[c] = VS'($urandom); t_v2y[c] = VS'($urandom);
            t_eq[c] = PS'($urandom);
        end
    endtask

    task automatic rand_vec(output vec_t v);
        int f1, f2;
        v.k   = int'($urandom_range(7, 0)) - 4;
        v.b   = int'($urandom_range(7, 0)) - 4;
        v.x1  = int'($urandom_range(255, 0)) - 128;
        v.y1  = int'($urandom_range(255, 0)) - 128;
        v.x2  = int'($urandom_range(255, 0)) - 128;
        v.y2  = int'($urandom_range(255, 0)) - 128;
        if ($urandom_range(7, 0) == 0) begin v.x2 = v.x1; v.y2 = v.y1; end
        v.v1x = int'($urandom_range(127, 0)) - 64;
        v.v1y = int'($urandom_range(127, 0)) - 64;
        v.v2x = int'($urandom_range(127, 0)) - 64;
        v.v2y = int'($urandom_range(127, 0)) - 64;
        v.eq  = int'($urandom_range(255, 0));
        model(v, f1, f2);
        v.fx = f1;
        v.fy = f2;
    endtask

    task automatic start_batch();
        @(negedge clk_in);
        chk("ready_before_accept", int'(input_ready), 1);
        input_valid = 1'b1;
        @(posedge clk_in);
        #1 input_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!result_valid && n < 400);
    endtask

    task automatic check_forces(input string tag);
        for (int c = 0; c < NS; c++) begin
            chk($sformatf("%s fx[%0d]", tag, c), int'(fx[c]), e_fx[c]);
            chk($sformatf("%s fy[%0d]", tag, c), int'(fy[c]), e_fy[c]);
        end
    endtask

    task automatic full_batch(input string tag);
        int n;
        start_batch();
        wait_result(n);
        chk({tag, " latency"}, n, LAT);
        check_forces(tag);
        @(negedge clk_in);
        chk({tag, " pulse_width"}, int'(result_valid), 0);
    endtask

    initial begin
        int n, rv_seen;
        vec_t v;
        //           k  b  x1   y1  x2   y2  v1x v1y v2x v2y eq   fx    fy
        tbl[0] = '{  1, 0,   2,   2,  2,   5,  0,  0,  0,  0, 2,    0,    1};
        tbl[1] = '{  1, 0,   2,   2,  5,   6,  0,  0,  0,  0, 2,    1,    2};
        tbl[2] = '{  1, 0,   2,   2,  2,   4,  0,  0,  0,  0, 2,    0,    0};
        tbl[3] = '{  3, 0, -13,  -8, 98, 111,  0,  0,  0,  0, 0,  127,  127};
        tbl[4] = '{  1, 1,   3,   3,  3,   3,  5,  6, -5,  6, 2,  -10,    0};
        tbl[5] = '{  3, 0,  98, 111,-13,  -8,  0,  0,  0,  0, 0, -128, -128};
        tbl[6] = '{  1, 0,   0,   0,  3,   4,  0,  0,  0,  0, 10,  -3,   -4};
        tbl[7] = '{  1, 0,   0,   0,  3,   4,  0,  0,  0,  0, 7,   -1,   -1};

        rst_in = 1'b1;
        input_valid = 1'b0;
        scramble();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset result_valid", int'(result_valid), 0);
        for (int c = 0; c < NS; c++) begin
            chk($sformatf("reset fx[%0d]", c), int'(fx[c]), 0);
            chk($sformatf("reset fy[%0d]", c), int'(fy[c]), 0);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready after reset", int'(input_ready), 1);

        for (int bt = 0; bt < 2; bt++) begin
            for (int c = 0; c < NS; c++) set_ch(c, tbl[bt * NS + c]);
            full_batch($sformatf("table%0d", bt));
        end

        // Busy-time input_valid is ignored; a new batch is taken on the result_valid cycle.
        for (int c = 0; c < NS; c++) set_ch(c, tbl[c]);
        @(negedge clk_in);
        input_valid = 1'b1;
        @(posedge clk_in);
        #1;
        for (int c = 0; c < NS; c++) begin a_fx[c] = e_fx[c]; a_fy[c] = e_fy[c]; end
        for (int c = 0; c < NS; c++) set_ch(c, tbl[NS + c]);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (n == 50) chk("ready low while busy", int'(input_ready), 0);
        end while (!result_valid && n < 400);
        chk("b2b first latency", n, LAT);
        chk("ready on result cycle", int'(input_ready), 1);
        for (int c = 0; c < NS; c++) begin
            chk($sformatf("b2b A fx[%0d]", c), int'(fx[c]), a_fx[c]);
            chk($sformatf("b2b A fy[%0d]", c), int'(fy[c]), a_fy[c]);
        end
        @(posedge clk_in);
        #1 input_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
            if (n == 25) chk("hold ch0 before store", int'(fx[0]), a_fx[0]);
            if (n == 26) begin
                chk("ch0 updated at store", int'(fx[0]), e_fx[0]);
                chk("ch1 held after ch0 store", int'(fx[1]), a_fx[1]);
            end
        end while (!result_valid && n < 400);
        chk("b2b second latency", n, LAT);
        check_forces("b2b B");

        // Reset 40 cycles into a batch: outputs cleared, no completion pulse.
        for (int c = 0; c < NS; c++) begin rand_vec(v); set_ch(c, v); end
        start_batch();
        repeat (39) @(negedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("midreset result_valid", int'(result_valid), 0);
        for (int c = 0; c < NS; c++) begin
            chk($sformatf("midreset fx[%0d]", c), int'(fx[c]), 0);
            chk($sformatf("midreset fy[%0d]", c), int'(fy[c]), 0);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready after midreset", int'(input_ready), 1);
        rv_seen = 0;
        repeat (150) begin
            @(negedge clk_in);
            if (result_valid) rv_seen++;
        end
        chk("no pulse after abort", rv_seen, 0);

        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < NS; c++) begin rand_vec(v); set_ch(c, v); end
            full_batch($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
